// File: rtl/rgb_hsv_pipe.sv
// Three-stage RGB->HSV converter with valid/ready backpressure and a USER sideband.
// Define RGB_HSV_MASK_EN to register an HSV-window match flag alongside out_h.
module rgb_hsv_pipe #(
    parameter int COMP_W = 8,
    parameter int SAT_W  = 8,
    parameter int USER_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COMP_W-1:0] in_r,
    input  logic [COMP_W-1:0] in_g,
    input  logic [COMP_W-1:0] in_b,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_h,
    output logic [SAT_W-1:0]  out_s,
    output logic [COMP_W-1:0] out_v,
    output logic [USER_W-1:0] out_user,
    input  logic [8:0]        cfg_h_lo,
    input  logic [8:0]        cfg_h_hi,
    input  logic [SAT_W-1:0]  cfg_s_min,
    input  logic [COMP_W-1:0] cfg_v_min,
    output logic              out_mask
);
    localparam int NUM_W   = COMP_W + 6;
    localparam int SATP_W  = COMP_W + SAT_W;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    typedef enum logic [1:0] {SEC_R = 2'd0, SEC_G = 2'd1, SEC_B = 2'd2} sector_e;

    logic adv;

    // Stage 1
    logic              s1_valid_q, s1_valid_d;
    logic [COMP_W-1:0] s1_max_q, s1_max_d, s1_diff_q, s1_diff_d, s1_num_q, s1_num_d;
    sector_e           s1_sec_q, s1_sec_d;
    logic              s1_pos_q, s1_pos_d;
    logic [USER_W-1:0] s1_user_q, s1_user_d;
    // Stage 2
    logic              s2_valid_q, s2_valid_d;
    logic [5:0]        s2_quo_q, s2_quo_d;
    logic [SAT_W-1:0]  s2_sat_q, s2_sat_d;
    sector_e           s2_sec_q, s2_sec_d;
    logic              s2_pos_q, s2_pos_d, s2_zero_q, s2_zero_d;
    logic [COMP_W-1:0] s2_max_q, s2_max_d;
    logic [USER_W-1:0] s2_user_q, s2_user_d;
    // Stage 3 (outputs)
    logic              out_valid_q, out_valid_d, out_mask_q, out_mask_d;
    logic [8:0]        out_h_q, out_h_d;
    logic [SAT_W-1:0]  out_s_q, out_s_d;
    logic [COMP_W-1:0] out_v_q, out_v_d;
    logic [USER_W-1:0] out_user_q, out_user_d;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        logic [COMP_W-1:0] mx, mn, nm;
        sector_e           sec;
        logic              pos;
        // Ties resolve toward R, then G, which keeps greys in the R sector.
        if (in_r >= in_g && in_r >= in_b) begin
            sec = SEC_R; mx = in_r; pos = (in_g >= in_b);
            nm  = pos ? in_g - in_b : in_b - in_g;
        end else if (in_g >= in_b) begin
            sec = SEC_G; mx = in_g; pos = (in_b >= in_r);
            nm  = pos ? in_b - in_r : in_r - in_b;
        end else begin
            sec = SEC_B; mx = in_b; pos = (in_r >= in_g);
            nm  = pos ? in_r - in_g : in_g - in_r;
        end
        mn = in_r;
        if (in_g < mn) mn = in_g;
        if (in_b < mn) mn = in_b;

        s1_valid_d = adv ? in_valid : s1_valid_q;
        s1_max_d   = adv ? mx       : s1_max_q;
        s1_diff_d  = adv ? mx - mn  : s1_diff_q;
        s1_num_d   = adv ? nm       : s1_num_q;
        s1_sec_d   = adv ? sec      : s1_sec_q;
        s1_pos_d   = adv ? pos      : s1_pos_q;
        s1_user_d  = adv ? in_user  : s1_user_q;
    end

    always_comb begin
        logic [NUM_W-1:0]  num60, quo;
        logic [SATP_W-1:0] sat_full;
        num60 = NUM_W'(s1_num_q) * NUM_W'(60);
        quo   = '0;
        if (s1_diff_q != '0) quo = num60 / NUM_W'(s1_diff_q);
        sat_full = '0;
        if (s1_max_q != '0) sat_full = (SATP_W'(s1_diff_q) * SATP_W'(SAT_MAX)) / SATP_W'(s1_max_q);

        s2_valid_d = adv ? s1_valid_q          : s2_valid_q;
        s2_quo_d   = adv ? 6'(quo)             : s2_quo_q;
        s2_sat_d   = adv ? SAT_W'(sat_full)    : s2_sat_q;
        s2_sec_d   = adv ? s1_sec_q            : s2_sec_q;
        s2_pos_d   = adv ? s1_pos_q            : s2_pos_q;
        s2_zero_d  = adv ? (s1_diff_q == '0)   : s2_zero_q;
        s2_max_d   = adv ? s1_max_q            : s2_max_q;
        s2_user_d  = adv ? s1_user_q           : s2_user_q;
    end

    always_comb begin
        logic [9:0] q10, hue;
        logic       mask;
        q10 = 10'(s2_quo_q);
        case (s2_sec_q)
            SEC_R:   hue = s2_pos_q ? q10 : 10'd360 - q10;
            SEC_G:   hue = s2_pos_q ? 10'd120 + q10 : 10'd120 - q10;
            default: hue = s2_pos_q ? 10'd240 + q10 : 10'd240 - q10;
        endcase
        if (hue == 10'd360 || s2_zero_q) hue = 10'd0;

`ifdef RGB_HSV_MASK_EN
        begin
            logic hue_in;
            // lo > hi describes a window that wraps through 0 degrees.
            if (cfg_h_lo <= cfg_h_hi)
                hue_in = (hue[8:0] >= cfg_h_lo) && (hue[8:0] <= cfg_h_hi);
            else
                hue_in = (hue[8:0] >= cfg_h_lo) || (hue[8:0] <= cfg_h_hi);
            mask = hue_in && (s2_sat_q >= cfg_s_min) && (s2_max_q >= cfg_v_min);
        end
`else
        mask = 1'b0;
`endif

        out_valid_d = adv ? s2_valid_q : out_valid_q;
        out_h_d     = adv ? hue[8:0]   : out_h_q;
        out_s_d     = adv ? s2_sat_q   : out_s_q;
        out_v_d     = adv ? s2_max_q   : out_v_q;
        out_user_d  = adv ? s2_user_q  : out_user_q;
        out_mask_d  = adv ? mask       : out_mask_q;
    end

`ifndef RGB_HSV_MASK_EN
    logic unused_cfg;
    assign unused_cfg = ^{cfg_h_lo, cfg_h_hi, cfg_s_min, cfg_v_min};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;  s1_max_q  <= '0;  s1_diff_q <= '0;  s1_num_q <= '0;
            s1_sec_q    <= SEC_R; s1_pos_q  <= 1'b0; s1_user_q <= '0;
            s2_valid_q  <= 1'b0;  s2_quo_q  <= '0;  s2_sat_q  <= '0;  s2_sec_q <= SEC_R;
            s2_pos_q    <= 1'b0;  s2_zero_q <= 1'b0; s2_max_q <= '0;  s2_user_q <= '0;
            out_valid_q <= 1'b0;  out_h_q   <= '0;  out_s_q   <= '0;  out_v_q  <= '0;
            out_user_q  <= '0;    out_mask_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;  s1_max_q  <= s1_max_d;  s1_diff_q <= s1_diff_d;
            s1_num_q    <= s1_num_d;    s1_sec_q  <= s1_sec_d;  s1_pos_q  <= s1_pos_d;
            s1_user_q   <= s1_user_d;
            s2_valid_q  <= s2_valid_d;  s2_quo_q  <= s2_quo_d;  s2_sat_q  <= s2_sat_d;
            s2_sec_q    <= s2_sec_d;    s2_pos_q  <= s2_pos_d;  s2_zero_q <= s2_zero_d;
            s2_max_q    <= s2_max_d;    s2_user_q <= s2_user_d;
            out_valid_q <= out_valid_d; out_h_q   <= out_h_d;   out_s_q   <= out_s_d;
            out_v_q     <= out_v_d;     out_user_q <= out_user_d; out_mask_q <= out_mask_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_h     = out_h_q;
    assign out_s     = out_s_q;
    assign out_v     = out_v_q;
    assign out_user  = out_user_q;
    assign out_mask  = out_mask_q;
endmodule

// File: tb/tb_rgb_hsv_pipe.sv
// Directed-vector bench for rgb_hsv_pipe (COMP_W=8, SAT_W=8, USER_W=3).
module tb_rgb_hsv_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_mask;
    logic [7:0] in_r, in_g, in_b, out_s, out_v;
    logic [2:0] in_user, out_user;
    logic [8:0] out_h, cfg_h_lo, cfg_h_hi;
    logic [7:0] cfg_s_min, cfg_v_min;

    always #5 clk = ~clk;

    rgb_hsv_pipe #(.COMP_W(8), .SAT_W(8), .USER_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_user(out_user),
        .cfg_h_lo(cfg_h_lo), .cfg_h_hi(cfg_h_hi),
        .cfg_s_min(cfg_s_min), .cfg_v_min(cfg_v_min),
        .out_mask(out_mask)
    );

    typedef struct {
        int r, g, b, u, h, s, v, m, t;
        bit lat;
    } vec_t;

    vec_t stim_q[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   hold_valid = 0;
    int   hold_h, hold_s, hold_v, hold_u, hold_m;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic vec_t mk(input int r, g, b, u, h, s, v, m, input bit lat);
        vec_t x;
        x.r = r; x.g = g; x.b = b; x.u = u; x.h = h; x.s = s; x.v = v; x.m = m;
        x.t = 0; x.lat = lat;
        return x;
    endfunction

    // One clock cycle: drive at negedge, observe 1 time unit later.
    task automatic cycle(input bit drive, input bit rdy);
        vec_t e;
        @(negedge clk);
        cyc++;
        if (drive && stim_q.size() > 0) begin
            in_valid = 1'b1;
            in_r = 8'(stim_q[0].r); in_g = 8'(stim_q[0].g); in_b = 8'(stim_q[0].b);
            in_user = 3'(stim_q[0].u);
        end else begin
            in_valid = 1'b0;
        end
        out_ready = rdy;
        #1;
        if (hold_valid) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_h", int'(out_h), hold_h);
            chk("hold_s", int'(out_s), hold_s);
            chk("hold_v", int'(out_v), hold_v);
            chk("hold_user", int'(out_user), hold_u);
            chk("hold_mask", int'(out_mask), hold_m);
        end
        hold_valid = 1'b0;
        if (!out_valid) chk("in_ready_idle", int'(in_ready), 1);
        if (out_valid && !out_ready) begin
            chk("in_ready_stall", int'(in_ready), 0);
            hold_valid = 1'b1;
            hold_h = out_h; hold_s = out_s; hold_v = out_v; hold_u = out_user; hold_m = out_mask;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("out rgb=(%0d,%0d,%0d) h=%0d s=%0d v=%0d user=%0d mask=%0d",
                         e.r, e.g, e.b, out_h, out_s, out_v, out_user, out_mask);
                chk("h", int'(out_h), e.h);
                chk("s", int'(out_s), e.s);
                chk("v", int'(out_v), e.v);
                chk("user", int'(out_user), e.u);
`ifdef RGB_HSV_MASK_EN
                chk("mask", int'(out_mask), e.m);
`else
                chk("mask", int'(out_mask), 0);
`endif
                if (e.lat) chk("latency", cyc - e.t, 3);
            end
        end
        if (in_valid && in_ready) begin
            e = stim_q.pop_front();
            e.t = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        chk("drain_timeout", stim_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        int ramp_h[16] = '{0, 3, 7, 11, 15, 18, 22, 26, 30, 33, 37, 41, 45, 48, 52, 56};
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_r = '0; in_g = '0; in_b = '0; in_user = '0;
        cfg_h_lo = 9'd340; cfg_h_hi = 9'd20; cfg_s_min = 8'd100; cfg_v_min = 8'd64;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_h", int'(out_h), 0);
        chk("rst_out_s", int'(out_s), 0);
        chk("rst_out_v", int'(out_v), 0);
        chk("rst_out_user", int'(out_user), 0);
        chk("rst_out_mask", int'(out_mask), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back to back.
        stim_q.push_back(mk(255,   0,   0, 1,   0, 255, 255, 1, 1));
        stim_q.push_back(mk(  0, 255,   0, 2, 120, 255, 255, 0, 1));
        stim_q.push_back(mk(  0,   0, 255, 3, 240, 255, 255, 0, 1));
        stim_q.push_back(mk(128, 128, 128, 4,   0,   0, 128, 0, 1));
        stim_q.push_back(mk(  0,   0,   0, 5,   0,   0,   0, 0, 1));
        stim_q.push_back(mk(200, 100,  50, 6,  20, 191, 200, 1, 1));
        stim_q.push_back(mk(255,   0, 128, 7, 330, 255, 255, 0, 1));
        stim_q.push_back(mk(255,   0,   1, 0,   0, 255, 255, 1, 1));
        run_until_empty(100);

        // 16-pixel ramp (255, 16i, 0) with a 5-cycle downstream stall.
        for (int i = 0; i < 16; i++)
            stim_q.push_back(mk(255, 16 * i, 0, i % 8, ramp_h[i], 255, 255, (i <= 5) ? 1 : 0, 0));
        n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            cycle(1'b1, !(n >= 6 && n < 11));
            n++;
        end
        chk("ramp_timeout", stim_q.size() + exp_q.size(), 0);

        // Reset with three pixels in flight.
        stim_q.push_back(mk(10, 20, 30, 1, 0, 0, 0, 0, 0));
        stim_q.push_back(mk(40, 50, 60, 2, 0, 0, 0, 0, 0));
        stim_q.push_back(mk(70, 80, 90, 3, 0, 0, 0, 0, 0));
        repeat (3) cycle(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_out_h", int'(out_h), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        stim_q.delete();
        exp_q.delete();
        hold_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            chk("post_rst_no_stale", int'(out_valid), 0);
        end

        stim_q.push_back(mk(0, 0, 255, 5, 240, 255, 255, 0, 1));
        run_until_empty(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
